// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: independent GPR/FPR round-robin arbitration onto registered write ports.
// Define REGFILE_WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority without pointers.
module regfile_wb_arbiter #(
   parameter int NUM_SRC = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_SRC-1:0]    src_valid,
   output logic [NUM_SRC-1:0]    src_ready,
   input  logic [NUM_SRC-1:0]    src_fpr,
   input  logic [5*NUM_SRC-1:0]  src_addr,
   input  logic [32*NUM_SRC-1:0] src_data,
   output logic                  gpr_write_en,
   output logic [4:0]            gpr_write_addr,
   output logic [31:0]           gpr_write_data,
   output logic                  fpr_write_en,
   output logic [4:0]            fpr_write_addr,
   output logic [31:0]           fpr_write_data,
   output logic                  conflict
);

   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef struct packed {
      logic          hit;
      logic [PW-1:0] idx;
   } pick_t;

   // First member of set at or after ptr, wrapping modulo NUM_SRC.
   function automatic pick_t pick(input logic [NUM_SRC-1:0] set, input logic [PW-1:0] ptr);
      pick_t r;
      int    j;
      r = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         j = (int'(ptr) + k) % NUM_SRC;
         if (!r.hit && set[j]) begin
            r.hit = 1'b1;
            r.idx = PW'(j);
         end
      end
      return r;
   endfunction

   function automatic logic multi(input logic [NUM_SRC-1:0] set);
      return |(set & (set - NUM_SRC'(1)));
   endfunction

   logic [NUM_SRC-1:0] gpr_set;
   logic [NUM_SRC-1:0] fpr_set;
   logic [PW-1:0]      gpr_ptr;
   logic [PW-1:0]      fpr_ptr;
   pick_t              gpr_pick;
   pick_t              fpr_pick;
   logic [4:0]         gpr_sel_addr;
   logic [31:0]        gpr_sel_data;
   logic [4:0]         fpr_sel_addr;
   logic [31:0]        fpr_sel_data;

   assign gpr_set  = src_valid & ~src_fpr;
   assign fpr_set  = src_valid & src_fpr;
   assign gpr_pick = pick(gpr_set, gpr_ptr);
   assign fpr_pick = pick(fpr_set, fpr_ptr);

   assign gpr_sel_addr = src_addr[5*int'(gpr_pick.idx) +: 5];
   assign gpr_sel_data = src_data[32*int'(gpr_pick.idx) +: 32];
   assign fpr_sel_addr = src_addr[5*int'(fpr_pick.idx) +: 5];
   assign fpr_sel_data = src_data[32*int'(fpr_pick.idx) +: 32];

   always_comb begin
      src_ready = '0;
      if (gpr_pick.hit) src_ready[gpr_pick.idx] = 1'b1;
      if (fpr_pick.hit) src_ready[fpr_pick.idx] = 1'b1;
   end

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
   assign gpr_ptr = '0;
   assign fpr_ptr = '0;
`else
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
      return (idx == PW'(NUM_SRC-1)) ? '0 : idx + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpr_ptr <= '0;
         fpr_ptr <= '0;
      end else begin
         if (gpr_pick.hit) gpr_ptr <= next_ptr(gpr_pick.idx);
         if (fpr_pick.hit) fpr_ptr <= next_ptr(fpr_pick.idx);
      end
   end
`endif

   // A grant to GPR $zero is consumed but never strobed into the file.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpr_write_en   <= 1'b0;
         gpr_write_addr <= '0;
         gpr_write_data <= '0;
         fpr_write_en   <= 1'b0;
         fpr_write_addr <= '0;
         fpr_write_data <= '0;
         conflict       <= 1'b0;
      end else begin
         gpr_write_en <= gpr_pick.hit && (gpr_sel_addr != 5'd0);
         fpr_write_en <= fpr_pick.hit;
         if (gpr_pick.hit) begin
            gpr_write_addr <= gpr_sel_addr;
            gpr_write_data <= gpr_sel_data;
         end
         if (fpr_pick.hit) begin
            fpr_write_addr <= fpr_sel_addr;
            fpr_write_data <= fpr_sel_data;
         end
         conflict <= multi(gpr_set) | multi(fpr_set);
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed per-cycle vectors, decoupled negedge monitor.
module tb_regfile_wb_arbiter;
   localparam int N = 4;
`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   src_valid = '0;
   logic [N-1:0]   src_ready;
   logic [N-1:0]   src_fpr = '0;
   logic [5*N-1:0] src_addr;
   logic [32*N-1:0] src_data;
   logic           gpr_write_en, fpr_write_en, conflict;
   logic [4:0]     gpr_write_addr, fpr_write_addr;
   logic [31:0]    gpr_write_data, fpr_write_data;

   logic [4:0]     a [N];
   logic [31:0]    d [N];

   int errors = 0;
   int checks = 0;

   // Per-cycle entry: {zero_chk, ready_chk, ready[3:0], conflict, gpr_en, fpr_en}
   logic [8:0]  cyc_q [$];
   logic [36:0] gpr_q [$];
   logic [36:0] fpr_q [$];
   logic        p_g = 1'b0, p_f = 1'b0, p_c = 1'b0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         src_addr[5*i +: 5]   = a[i];
         src_data[32*i +: 32] = d[i];
      end
   end

   regfile_wb_arbiter #(.NUM_SRC(N)) dut (
      .clk(clk), .reset(reset),
      .src_valid(src_valid), .src_ready(src_ready), .src_fpr(src_fpr),
      .src_addr(src_addr), .src_data(src_data),
      .gpr_write_en(gpr_write_en), .gpr_write_addr(gpr_write_addr), .gpr_write_data(gpr_write_data),
      .fpr_write_en(fpr_write_en), .fpr_write_addr(fpr_write_addr), .fpr_write_data(fpr_write_data),
      .conflict(conflict)
   );

   // Drive one cycle; er is the hand-computed grant vector for this cycle.
   task automatic step(input logic [N-1:0] v, input logic [N-1:0] f, input logic [N-1:0] er,
                       input logic rst, input logic z);
      logic [N-1:0] gs, fs;
      @(posedge clk);
      #1;
      reset     = rst;
      src_valid = v;
      src_fpr   = f;
      if (rst) begin
         gpr_q.delete();
         fpr_q.delete();
         cyc_q.push_back({z, 1'b0, er, 3'b000});
         p_g = 1'b0; p_f = 1'b0; p_c = 1'b0;
      end else begin
         cyc_q.push_back({z, 1'b1, er, p_c, p_g, p_f});
         gs  = v & ~f;
         fs  = v & f;
         p_c = ($countones(gs) > 1) || ($countones(fs) > 1);
         p_g = 1'b0;
         p_f = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (er[i]) begin
               if (f[i]) begin
                  p_f = 1'b1;
                  fpr_q.push_back({a[i], d[i]});
               end else if (a[i] != 5'd0) begin
                  p_g = 1'b1;
                  gpr_q.push_back({a[i], d[i]});
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      logic [8:0]  e;
      logic [36:0] w;
      if (cyc_q.size() != 0) begin
         e = cyc_q.pop_front();
         if (e[7]) begin
            checks++;
            if (src_ready !== e[6:3]) begin
               errors++;
               $display("FAIL ready t=%0t: got %b want %b", $time, src_ready, e[6:3]);
            end
         end
         checks++;
         if (conflict !== e[2]) begin
            errors++;
            $display("FAIL conflict t=%0t: got %b want %b", $time, conflict, e[2]);
         end
         checks++;
         if (gpr_write_en !== e[1]) begin
            errors++;
            $display("FAIL gpr_en t=%0t: got %b want %b", $time, gpr_write_en, e[1]);
         end
         checks++;
         if (fpr_write_en !== e[0]) begin
            errors++;
            $display("FAIL fpr_en t=%0t: got %b want %b", $time, fpr_write_en, e[0]);
         end
         if (e[8]) begin
            checks++;
            if ({gpr_write_addr, gpr_write_data, fpr_write_addr, fpr_write_data} !== '0) begin
               errors++;
               $display("FAIL zero_outputs t=%0t: got gpr %h/%h fpr %h/%h want 0", $time,
                        gpr_write_addr, gpr_write_data, fpr_write_addr, fpr_write_data);
            end
         end
      end
      if (gpr_write_en === 1'b1) begin
         checks++;
         if (gpr_q.size() == 0) begin
            errors++;
            $display("FAIL gpr_write t=%0t: got %h/%h want no write", $time, gpr_write_addr, gpr_write_data);
         end else begin
            w = gpr_q.pop_front();
            if ({gpr_write_addr, gpr_write_data} !== w) begin
               errors++;
               $display("FAIL gpr_write t=%0t: got %h/%h want %h/%h", $time,
                        gpr_write_addr, gpr_write_data, w[36:32], w[31:0]);
            end
         end
      end
      if (fpr_write_en === 1'b1) begin
         checks++;
         if (fpr_q.size() == 0) begin
            errors++;
            $display("FAIL fpr_write t=%0t: got %h/%h want no write", $time, fpr_write_addr, fpr_write_data);
         end else begin
            w = fpr_q.pop_front();
            if ({fpr_write_addr, fpr_write_data} !== w) begin
               errors++;
               $display("FAIL fpr_write t=%0t: got %h/%h want %h/%h", $time,
                        fpr_write_addr, fpr_write_data, w[36:32], w[31:0]);
            end
         end
      end
   end

   // Valid must not drop before acceptance (reset cycles excluded).
   logic [N-1:0] prev_v = '0, prev_r = '0;
   logic         prev_rst = 1'b1;
   always @(negedge clk) begin
      if (!reset && !prev_rst && ((prev_v & ~prev_r & ~src_valid) != '0)) begin
         errors++;
         $display("FAIL protocol t=%0t: valid dropped unaccepted %b", $time, prev_v & ~prev_r & ~src_valid);
      end
      prev_v   = src_valid;
      prev_r   = src_ready;
      prev_rst = reset;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout want finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         a[i] = '0;
         d[i] = '0;
      end
      // reset and idle
      step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
      step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
      // single GPR request
      a[2] = 5'd5; d[2] = 32'hDEADBEEF;
      step(4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      // three GPR requesters from a fresh pointer
      a[0] = 5'd1; d[0] = 32'h0000_0A01;
      a[1] = 5'd2; d[1] = 32'h0000_0A02;
      a[3] = 5'd3; d[3] = 32'h0000_0A03;
      step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
      step(4'b1011, 4'b0000, 4'b0001, 1'b0, 1'b0);
      step(4'b1011, 4'b0000, FIXED ? 4'b0001 : 4'b0010, 1'b0, 1'b0);
      step(4'b1011, 4'b0000, FIXED ? 4'b0001 : 4'b1000, 1'b0, 1'b0);
      step(4'b1011, 4'b0000, 4'b0001, 1'b0, 1'b0);
      step(4'b1010, 4'b0000, 4'b0010, 1'b0, 1'b0);
      step(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      // simultaneous GPR and FPR to address 7
      a[0] = 5'd7; d[0] = 32'h1111_0000;
      a[1] = 5'd7; d[1] = 32'h2222_0000;
      step(4'b0011, 4'b0010, 4'b0011, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      // GPR $zero suppressed; FPR address 0 written normally
      a[0] = 5'd0; d[0] = 32'h12345678;
      a[2] = 5'd0; d[2] = 32'hABCD0000;
      step(4'b0101, 4'b0100, 4'b0101, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      // reset pulse while three GPR requesters are active
      a[1] = 5'd9;  d[1] = 32'h0000_0B09;
      a[2] = 5'd10; d[2] = 32'h0000_0B0A;
      a[3] = 5'd11; d[3] = 32'h0000_0B0B;
      step(4'b1110, 4'b0000, 4'b0010, 1'b0, 1'b0);
      step(4'b1110, 4'b0000, FIXED ? 4'b0010 : 4'b0100, 1'b0, 1'b0);
      step(4'b1110, 4'b0000, 4'b0000, 1'b1, 1'b1);
      step(4'b1110, 4'b0000, 4'b0010, 1'b0, 1'b0);
      step(4'b1100, 4'b0000, 4'b0100, 1'b0, 1'b0);
      step(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      // top index granted back to back, then pointer must sit at 0
      a[0] = 5'd20; d[0] = 32'h0000_0C00;
      a[3] = 5'd23; d[3] = 32'h0000_0C03;
      step(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
      step(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
      step(4'b1001, 4'b0000, 4'b0001, 1'b0, 1'b0);
      step(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      // FPR contention
      a[1] = 5'd12; d[1] = 32'h0000_0D01;
      a[2] = 5'd13; d[2] = 32'h0000_0D02;
      step(4'b0110, 4'b0110, 4'b0010, 1'b0, 1'b0);
      step(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      checks++;
      if (gpr_q.size() != 0 || fpr_q.size() != 0 || cyc_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got gpr=%0d fpr=%0d cyc=%0d pending want 0",
                  gpr_q.size(), fpr_q.size(), cyc_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the mini-MIPS register file. Up to NUM_SRC producers (ALU, load unit, FPU, GPR/FPR move unit) compete for the single GPR write port and the single FPR write port. Each cycle the block grants at most one GPR write and one FPR write, using independent round-robin pointers per file. It drives the register file's write ports from registered outputs.

## Interface
- NUM_SRC, 4: number of write-back requesters, 2..8.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- src_valid  in  NUM_SRC  request i present; held with payload stable until accepted.
- src_ready  out  NUM_SRC  combinational grant; transfer occurs when src_valid[i] & src_ready[i].
- src_fpr  in  NUM_SRC  target file of source i: 0 = GPR, 1 = FPR.
- src_addr  in  5*NUM_SRC  destination register; source i uses bits [5i+4:5i].
- src_data  in  32*NUM_SRC  write data; source i uses bits [32i+31:32i].
- gpr_write_en  out  1  GPR write strobe, registered.
- gpr_write_addr  out  5  GPR destination, registered.
- gpr_write_data  out  32  GPR data, registered.
- fpr_write_en  out  1  FPR write strobe, registered.
- fpr_write_addr  out  5  FPR destination, registered.
- fpr_write_data  out  32  FPR data, registered.
- conflict  out  1  registered; 1 when the previous cycle had a file with ≥2 valid requesters.

## Operation
- Requests are split into a GPR set (valid & ~fpr) and an FPR set (valid & fpr), and each set is arbitrated separately.
- GPR arbitration:
  - Scan from gpr_ptr upward, modulo NUM_SRC; the first set member wins.
  - On a grant to winner w, gpr_ptr <= (w+1) mod NUM_SRC.
  - With no grant, gpr_ptr holds.
- FPR arbitration is identical, using fpr_ptr.
- src_ready[i] is 1 only for the winner in its file. At most two ready bits are set per cycle.
- A GPR request to address 0 is granted and consumed normally. Its registered gpr_write_en is forced to 0 ($zero is never written). FPR address 0 is a normal register.
- Outputs are loaded only from the winner. With no winner in a file, its write_en <= 0 and its addr/data hold their previous values.
- A GPR winner and an FPR winner in the same cycle are both accepted, with no interaction between them.
- ready does not depend on any downstream back-pressure. The register file always accepts a write.

## Timing
- Reset values:
  - All write_en, addr, data and conflict outputs are 0.
  - gpr_ptr = fpr_ptr = 0.
  - src_ready is combinational, so it is active as soon as reset deasserts.
- Latency: a request accepted at edge t produces write_en = 1 during cycle t+1. The register file commits it at edge t+1.
- Throughput: one GPR write and one FPR write per cycle, sustained.
- Fairness: a source held valid is granted within NUM_SRC cycles.
- Reset asserted mid-operation immediately clears outputs and pointers. Any registered, not-yet-committed write is dropped. Sources must re-present their requests.
- Pointer wrap: a winner at NUM_SRC-1 sets the pointer to 0.
- src_valid dropping without acceptance is a protocol violation. Behaviour in that case is undefined; the bench asserts against it.

## Configuration
- REGFILE_WB_ARB_FIXED_PRIO_EN:
  - Defined: both files use fixed priority (lowest index wins), and the pointers are not implemented.
  - Undefined (default): round-robin as described above.
- The conflict output exists in both builds.

## Test plan
- Reset, then idle: all outputs 0 and src_ready = 0 while no source is valid. Asserting src_valid[2] (GPR, addr 5, data 0xDEADBEEF) gives src_ready[2] = 1 that cycle. The next cycle shows gpr_write_en = 1, addr = 5, data = 0xDEADBEEF.
- Sources 0, 1 and 3 all valid to GPR, held continuously: grants go 0, 1, 3, 0 on consecutive cycles, and conflict = 1 from the second cycle. With the fixed-priority macro defined, source 0 is granted every cycle.
- Source 0 to GPR addr 7 and source 1 to FPR addr 7 in the same cycle: both ready. Next cycle gpr_write_en = 1 and fpr_write_en = 1, each with its own data.
- GPR write to address 0 with data 0x12345678: src_ready = 1. Next cycle gpr_write_en = 0, while the FPR port is unaffected.
- Three GPR requesters active and reset pulsed for one cycle: outputs go to 0 immediately and the pointer returns to 0. The first grant after release goes to the lowest valid index.
- Single GPR requester at index NUM_SRC-1, granted twice in a row: the pointer wraps to 0, and the second grant still goes to NUM_SRC-1 with no idle cycle.
